// File: rtl/eth_pkg.sv
// eth_pkg: shared constants, receive state encoding and the byte-wide CRC32
// step used by the Ethernet receive framer.
//   PREAMBLE_BYTE / SFD_BYTE     : GMII preamble and start-of-frame delimiter
//   CRC_POLY / CRC_INIT          : IEEE 802.3 reflected CRC32 parameters
//   CRC_RESIDUE                  : register value after a frame plus its good FCS
//   rx_state_t                   : framer FSM states
//   crc32_byte()                 : advance the CRC register by one byte, LSB first
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DISCARD
  } rx_state_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// eth_crc32: byte-wide CRC32 register.
//   clk  : clock
//   rst  : synchronous active-high reset (loads CRC_INIT)
//   init : reload CRC_INIT (has priority over en)
//   en   : fold data into the register
//   data : byte to fold in
//   crc  : current register value (no final inversion)
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || init) crc <= CRC_INIT;
    else if (en)     crc <= crc32_byte(crc, data);
  end

endmodule

// File: rtl/eth_rx_frame.sv
// eth_rx_frame: GMII receive framer. Strips preamble/SFD, checks length and
// CRC32, and holds one good frame in a byte buffer until the host acks it.
// Optional build macro ETH_RX_MAC_FILTER_EN: accept only frames whose DA is
// i_mac_addr or broadcast; without it the framer is promiscuous.
// Ports:
//   i_rx_clk    : the only clock
//   i_rst       : synchronous active-high reset
//   i_rx_data   : GMII byte;  i_rx_dv : byte valid
//   i_mac_addr  : station MAC, DA byte0 = [47:40] (filter build only)
//   i_ack       : host done with pending frame (ignored when nothing pending)
//   i_rd_addr   : buffer read address; o_rd_data : registered read, 1-cycle latency
//   o_frame_len : pending frame length excluding FCS
//   o_irq_rx    : high while a frame is pending
//   o_err_cnt   : saturating runt/CRC/overflow count
//   o_drop_cnt  : saturating count of frames dropped while one was pending
module eth_rx_frame
  import eth_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int MIN_LEN = 64,
  parameter int CNT_W   = 16
) (
  input  logic              i_rx_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_dv,
  input  logic [47:0]       i_mac_addr,
  input  logic              i_ack,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data,
  output logic [ADDR_W-1:0] o_frame_len,
  output logic              o_irq_rx,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic [CNT_W-1:0]  o_drop_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  // cnt is one bit wider than the address so a completely full buffer
  // (DEPTH bytes) is distinguishable from an empty one.
  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  rx_state_t         state_q, state_d;
  logic [ADDR_W:0]   cnt;
  logic [31:0]       crc;
  logic              pending;
  logic              filter_miss;

  logic crc_init, crc_en, wr_en, cnt_clr, err_inc, drop_inc, frame_ok;

  logic [7:0] mem [DEPTH];

  // ---------------- FSM ----------------
  always_ff @(posedge i_rx_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    crc_init = 1'b0;
    crc_en   = 1'b0;
    wr_en    = 1'b0;
    cnt_clr  = 1'b0;
    err_inc  = 1'b0;
    drop_inc = 1'b0;
    frame_ok = 1'b0;
    case (state_q)
      ST_IDLE:
        if (i_rx_dv && i_rx_data == PREAMBLE_BYTE) state_d = ST_PREAMBLE;
      ST_PREAMBLE:
        if (!i_rx_dv)                        state_d = ST_IDLE;
        else if (i_rx_data == PREAMBLE_BYTE) state_d = ST_PREAMBLE;
        else if (i_rx_data == SFD_BYTE) begin
          // pending is the registered value, so an ack in this same cycle
          // does not rescue the new frame.
          if (pending) begin
            state_d  = ST_DISCARD;
            drop_inc = 1'b1;
          end else begin
            state_d  = ST_DATA;
            crc_init = 1'b1;
            cnt_clr  = 1'b1;
          end
        end else                             state_d = ST_DISCARD;
      ST_DATA:
        if (i_rx_dv) begin
          if (cnt == CNT_FULL) begin
            state_d = ST_DISCARD;
            err_inc = 1'b1;
          end else begin
            wr_en  = 1'b1;
            crc_en = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
          if (cnt < (ADDR_W+1)'(MIN_LEN) || crc != CRC_RESIDUE) err_inc  = 1'b1;
          else if (!filter_miss)                                frame_ok = 1'b1;
        end
      ST_DISCARD:
        if (!i_rx_dv) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  eth_crc32 u_crc (
    .clk  (i_rx_clk),
    .rst  (i_rst),
    .init (crc_init),
    .en   (crc_en),
    .data (i_rx_data),
    .crc  (crc)
  );

  always_ff @(posedge i_rx_clk) begin
    if (i_rst)        cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (wr_en)   cnt <= cnt + 1'b1;
  end

  // A frame can only be accepted when nothing is pending, so frame_ok and a
  // meaningful ack never coincide.
  always_ff @(posedge i_rx_clk) begin
    if (i_rst) begin
      pending     <= 1'b0;
      o_frame_len <= '0;
    end else if (frame_ok) begin
      pending     <= 1'b1;
      o_frame_len <= cnt[ADDR_W-1:0] - ADDR_W'(4);
    end else if (i_ack) begin
      pending     <= 1'b0;
    end
  end

  assign o_irq_rx = pending;

  always_ff @(posedge i_rx_clk) begin
    if (i_rst) begin
      o_err_cnt  <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (err_inc  && o_err_cnt  != '1) o_err_cnt  <= o_err_cnt  + 1'b1;
      if (drop_inc && o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + 1'b1;
    end
  end

  // Buffer: write port only active in DATA, so a pending frame stays intact.
  always_ff @(posedge i_rx_clk) begin
    if (wr_en) mem[cnt[ADDR_W-1:0]] <= i_rx_data;
  end

  always_ff @(posedge i_rx_clk) begin
    if (i_rst) o_rd_data <= '0;
    else       o_rd_data <= mem[i_rd_addr];
  end

  // ---------------- destination address filter ----------------
`ifdef ETH_RX_MAC_FILTER_EN
  logic       uc_ok, bc_ok;
  logic [7:0] da_exp;

  always_comb begin
    da_exp = '0;
    case (cnt[2:0])
      3'd0:    da_exp = i_mac_addr[47:40];
      3'd1:    da_exp = i_mac_addr[39:32];
      3'd2:    da_exp = i_mac_addr[31:24];
      3'd3:    da_exp = i_mac_addr[23:16];
      3'd4:    da_exp = i_mac_addr[15:8];
      3'd5:    da_exp = i_mac_addr[7:0];
      default: da_exp = '0;
    endcase
  end

  // Each flag stays set only while every DA byte seen so far matched.
  always_ff @(posedge i_rx_clk) begin
    if (i_rst || cnt_clr) begin
      uc_ok <= 1'b1;
      bc_ok <= 1'b1;
    end else if (wr_en && cnt < (ADDR_W+1)'(6)) begin
      if (i_rx_data != da_exp) uc_ok <= 1'b0;
      if (i_rx_data != 8'hFF)  bc_ok <= 1'b0;
    end
  end

  assign filter_miss = !(uc_ok || bc_ok);
`else
  logic unused_mac;
  assign unused_mac  = ^i_mac_addr;
  assign filter_miss = 1'b0;
`endif

endmodule

// File: tb/tb_eth_rx_frame.sv
module tb_eth_rx_frame;

  localparam int ADDR_W = 11;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_dv;
  logic [47:0]       mac_addr;
  logic              ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [ADDR_W-1:0] frame_len;
  logic              irq_rx;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  drop_cnt;

  always #5 clk = ~clk;

  eth_rx_frame #(.ADDR_W(ADDR_W), .MIN_LEN(64), .CNT_W(CNT_W)) dut (
    .i_rx_clk    (clk),
    .i_rst       (rst),
    .i_rx_data   (rx_data),
    .i_rx_dv     (rx_dv),
    .i_mac_addr  (mac_addr),
    .i_ack       (ack),
    .i_rd_addr   (rd_addr),
    .o_rd_data   (rd_data),
    .o_frame_len (frame_len),
    .o_irq_rx    (irq_rx),
    .o_err_cnt   (err_cnt),
    .o_drop_cnt  (drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] fb   [0:2099];
  logic [7:0] gold [0:2099];
  int         gold_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit-serial reference CRC over fb[0..n-1], LSB of each byte first.
  function automatic logic [31:0] crc_model(input int n);
    logic [31:0] c;
    logic        b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++) begin
        b = c[0] ^ fb[i][k];
        c = c >> 1;
        if (b) c = c ^ 32'hEDB88320;
      end
    return c;
  endfunction

  // n bytes of DA..payload, then the FCS (complemented CRC, LSB byte first).
  task automatic build(input int n, input int da, input bit corrupt, input int seed);
    logic [31:0] c;
    for (int i = 0; i < n; i++) fb[i] = 8'((i * 13 + seed) & 255);
    for (int i = 0; i < 6; i++)
      case (da)
        0:       fb[i] = 8'hFF;
        1:       fb[i] = 8'(i * 8'h11);
        default: fb[i] = (i == 5) ? 8'h56 : 8'(i * 8'h11);
      endcase
    c = ~crc_model(n);
    fb[n]   = c[7:0];
    fb[n+1] = c[15:8];
    fb[n+2] = c[23:16];
    fb[n+3] = c[31:24];
    if (corrupt) fb[n+2] = fb[n+2] ^ 8'h04;
  endtask

  task automatic save_gold(input int n);
    for (int i = 0; i < n; i++) gold[i] = fb[i];
    gold_n = n;
  endtask

  task automatic send(input int total, input bit ack_at_sfd, input bit bad_pre);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); rx_dv = 1'b1; rx_data = 8'h55;
    end
    @(negedge clk); rx_data = bad_pre ? 8'h12 : 8'hD5; ack = ack_at_sfd;
    for (int i = 0; i < total; i++) begin
      @(negedge clk); ack = 1'b0; rx_data = fb[i];
    end
    @(negedge clk); rx_dv = 1'b0; rx_data = 8'h00; ack = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_ack();
    chk("irq_before_ack", 32'(irq_rx), 32'd1);
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    chk("irq_after_ack", 32'(irq_rx), 32'd0);
  endtask

  task automatic readback(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < gold_n; i++) begin
      @(negedge clk); rd_addr = ADDR_W'(i);
      @(negedge clk);
      if (rd_data !== gold[i]) bad++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  typedef struct {
    int n; int da; bit corrupt; bit save; bit rb; bit do_ack;
    bit exp_irq; int exp_len; int exp_err; int exp_drop;
  } vec_t;

  vec_t vt [7];

  initial begin
    //           n    da crc sav rb  ack irq len  err drop
    vt[0] = '{  60,  0, 0,  1,  1,  0,  1,  60,  0,  0};  // good broadcast frame
    vt[1] = '{ 100,  0, 0,  0,  1,  1,  1,  60,  0,  1};  // dropped, buffer keeps frame 0
    vt[2] = '{  60,  0, 1,  0,  0,  0,  0,  60,  1,  1};  // FCS bit flipped
    vt[3] = '{  36,  0, 0,  0,  0,  0,  0,  60,  2,  1};  // 40-byte runt
    vt[4] = '{  59,  0, 0,  0,  0,  0,  0,  60,  3,  1};  // 63 bytes: one short
    vt[5] = '{ 124,  1, 0,  1,  1,  1,  1, 124,  3,  1};  // DA = station MAC
`ifdef ETH_RX_MAC_FILTER_EN
    vt[6] = '{  60,  2, 0,  0,  0,  0,  0, 124,  3,  1};  // foreign DA filtered
`else
    vt[6] = '{  60,  2, 0,  1,  1,  1,  1,  60,  3,  1};  // promiscuous accept
`endif

    rst = 1'b1; rx_data = '0; rx_dv = 1'b0; ack = 1'b0; rd_addr = '0;
    mac_addr = 48'h00_11_22_33_44_55;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_irq",  32'(irq_rx),    32'd0);
    chk("rst_len",  32'(frame_len), 32'd0);
    chk("rst_err",  32'(err_cnt),   32'd0);
    chk("rst_drop", 32'(drop_cnt),  32'd0);
    chk("rst_rd",   32'(rd_data),   32'd0);

    for (int v = 0; v < 7; v++) begin
      build(vt[v].n, vt[v].da, vt[v].corrupt, v * 31);
      if (vt[v].save) save_gold(vt[v].n);
      send(vt[v].n + 4, 1'b0, 1'b0);
      chk($sformatf("v%0d_irq", v),  32'(irq_rx),    32'(vt[v].exp_irq));
      chk($sformatf("v%0d_len", v),  32'(frame_len), 32'(vt[v].exp_len));
      chk($sformatf("v%0d_err", v),  32'(err_cnt),   32'(vt[v].exp_err));
      chk($sformatf("v%0d_drop", v), 32'(drop_cnt),  32'(vt[v].exp_drop));
      if (vt[v].rb)     readback($sformatf("v%0d_readback", v));
      if (vt[v].do_ack) do_ack();
    end

    // ack in the same cycle as an SFD: the new frame is still dropped
    build(64, 0, 1'b0, 7);
    send(68, 1'b0, 1'b0);
    chk("as_irq1", 32'(irq_rx),    32'd1);
    chk("as_len",  32'(frame_len), 32'd64);
    build(70, 0, 1'b0, 9);
    send(74, 1'b1, 1'b0);
    chk("as_irq0", 32'(irq_rx),    32'd0);
    chk("as_drop", 32'(drop_cnt),  32'd2);
    chk("as_len2", 32'(frame_len), 32'd64);

    // bad byte in place of SFD: discarded without counting
    build(60, 0, 1'b0, 3);
    send(64, 1'b0, 1'b1);
    chk("bp_irq",  32'(irq_rx),   32'd0);
    chk("bp_err",  32'(err_cnt),  32'd3);
    chk("bp_drop", 32'(drop_cnt), 32'd2);

    // overflow: 2049 bytes after SFD
    build(2045, 0, 1'b0, 5);
    send(2049, 1'b0, 1'b0);
    chk("ov_irq", 32'(irq_rx),  32'd0);
    chk("ov_err", 32'(err_cnt), 32'd4);

    // exactly 2048 bytes is accepted
    build(2044, 0, 1'b0, 11);
    save_gold(2044);
    send(2048, 1'b0, 1'b0);
    chk("full_irq", 32'(irq_rx),    32'd1);
    chk("full_len", 32'(frame_len), 32'd2044);
    chk("full_err", 32'(err_cnt),   32'd4);
    readback("full_readback");
    do_ack();

    // reset in the middle of a frame
    build(60, 0, 1'b0, 13);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); rx_dv = 1'b1; rx_data = 8'h55;
    end
    @(negedge clk); rx_data = 8'hD5;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); rx_data = fb[i];
      rst = (i == 20);
    end
    @(negedge clk); rx_dv = 1'b0; rx_data = 8'h00; rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("mr_irq",  32'(irq_rx),    32'd0);
    chk("mr_err",  32'(err_cnt),   32'd0);
    chk("mr_drop", 32'(drop_cnt),  32'd0);
    chk("mr_len",  32'(frame_len), 32'd0);
    send(64, 1'b0, 1'b0);
    chk("mr_next_irq", 32'(irq_rx),    32'd1);
    chk("mr_next_len", 32'(frame_len), 32'd60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a DUT problem stalls the stimulus.
  initial begin
    #900000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
